uart_cmd_assembler: RTL

- Sits directly downstream of the UART receiver and consumes its byte stream via the receiver's rx_rdy / rx_data / rx_rdy_clr handshake.
- Frames 5-byte command packets: SYNC, CMD, DATA_HI, DATA_LO, CHK.
- Validates each packet with an additive checksum and a per-byte timeout.
- Presents each good packet to the command-processing logic as cmd[7:0] and data[15:0], with a cmd_rdy / clr_cmd_rdy handshake.

---
 rtl/uart_cmd_assembler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: frames SYNC/CMD/DHI/DLO/CHK packets from the UART rx
// byte stream, checks the additive checksum and inter-byte timeout.
module uart_cmd_assembler #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int unsigned TMO_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        rx_rdy_clr,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        chk_err,
    output logic        tmo_err,
    output logic        ovr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DHI,
        S_DLO,
        S_CHK
    } state_t;

    // Hit is detected the cycle before the counter would reach TMO_CYCLES,
    // so the pulse coincides with the counter reaching it.
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  cmd_sh_q, cmd_sh_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        rx_rdy_clr_q, rx_rdy_clr_d;
    logic        chk_err_q, chk_err_d;
    logic        tmo_err_q, tmo_err_d;
    logic        ovr_err_q, ovr_err_d;

    logic        accept;
    logic        good;
    logic        tmo_hit;
    logic [7:0]  chk_sum;

    // The cycle after an accept rx_rdy is still high but must be ignored.
    assign accept = rx_rdy & ~rx_rdy_clr_q;

    // Next-state, datapath and pulse generation.
    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        cmd_sh_d     = cmd_sh_q;
        dhi_d        = dhi_q;
        dlo_d        = dlo_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        cmd_rdy_d    = cmd_rdy_q;
        rx_rdy_clr_d = accept;
        chk_err_d    = 1'b0;
        tmo_err_d    = 1'b0;
        ovr_err_d    = 1'b0;
        good         = 1'b0;
        chk_sum      = sum_q + rx_data;
        tmo_hit      = (state_q != S_IDLE) && !accept && (tmo_cnt_q == TMO_LAST);

        if (state_q == S_IDLE || accept) begin
            tmo_cnt_d = 16'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) state_d = S_CMD;
            end
            S_CMD: begin
                if (accept) begin
                    cmd_sh_d = rx_data;
                    sum_d    = rx_data;
                    state_d  = S_DHI;
                end
            end
            S_DHI: begin
                if (accept) begin
                    dhi_d   = rx_data;
                    sum_d   = chk_sum;
                    state_d = S_DLO;
                end
            end
            S_DLO: begin
                if (accept) begin
                    dlo_d   = rx_data;
                    sum_d   = chk_sum;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = S_IDLE;
                    if (chk_sum == 8'd0) good = 1'b1;
                    else chk_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            state_d   = S_IDLE;
            tmo_err_d = 1'b1;
            tmo_cnt_d = 16'd0;
        end

        if (good) begin
            cmd_d     = cmd_sh_q;
            data_d    = {dhi_q, dlo_q};
            cmd_rdy_d = 1'b1;
            ovr_err_d = cmd_rdy_q;
        end else if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= 16'd0;
            sum_q        <= 8'd0;
            cmd_sh_q     <= 8'd0;
            dhi_q        <= 8'd0;
            dlo_q        <= 8'd0;
            cmd_q        <= 8'd0;
            data_q       <= 16'd0;
            cmd_rdy_q    <= 1'b0;
            rx_rdy_clr_q <= 1'b0;
            chk_err_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
            ovr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            sum_q        <= sum_d;
            cmd_sh_q     <= cmd_sh_d;
            dhi_q        <= dhi_d;
            dlo_q        <= dlo_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            cmd_rdy_q    <= cmd_rdy_d;
            rx_rdy_clr_q <= rx_rdy_clr_d;
            chk_err_q    <= chk_err_d;
            tmo_err_q    <= tmo_err_d;
            ovr_err_q    <= ovr_err_d;
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign cmd        = cmd_q;
    assign data       = data_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign chk_err    = chk_err_q;
    assign tmo_err    = tmo_err_q;
    assign ovr_err    = ovr_err_q;

endmodule
